// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller.
//   - Forwarding mux select codes for the EX-stage 4:1 operand muxes
//   - XZR register index (never forwarded, never a hazard source)
//   - slot_t: per-stage destination tracking record
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // register file read
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB write-back value
  localparam logic [1:0] FWD_IMM   = 2'b11;  // immediate (operand B only)

  localparam int SLOT_RD_W = 5;
  localparam int XZR_IDX   = 31;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } slot_t;

endpackage

// File: rtl/hazard_slot.sv
// One pipeline-stage tracking slot for the forwarding controller.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the slot to a bubble
//   d     - record entering this stage
//   q     - record currently held by this stage
module hazard_slot
  import fwd_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Forwarding and load-use hazard controller for the EX-stage operand muxes.
// Tracks destination registers of the instructions in EX, MEM and WB, emits
// registered forwarding selects for the instruction entering EX, and stalls
// IF/ID for one cycle on a load-use dependency.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   id_valid              - ID holds a real instruction
//   id_rn, id_rm, id_rd   - ID source A, source B, destination registers
//   id_uses_rn/rm         - instruction reads operand A / B
//   id_use_imm            - operand B is the immediate
//   id_reg_write          - instruction writes rd
//   id_mem_read           - instruction is a load
//   flush                 - taken branch, kill the ID instruction
//   stall                 - combinational hold for PC and IF/ID
//   fwd_a_sel, fwd_b_sel  - registered EX operand mux selects
//   stall_count           - saturating count of stall cycles
module operand_forward_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_use_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] XZR = REG_W'(XZR_IDX);

  // A slot forwards register r when it will write r; XZR is hard-wired zero.
  function automatic logic slot_hits(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.reg_write && (REG_W'(s.rd) == r) && (r != XZR);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Youngest producer wins: the EX slot is next cycle's EX/MEM register.
  function automatic logic [1:0] pick_src(input slot_t ex, input slot_t mem,
                                          input logic [REG_W-1:0] r);
    if (slot_hits(ex, r)) begin
      return FWD_EXMEM;
    end else if (slot_hits(mem, r)) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

  slot_t      id_entry;
  slot_t      slot_q [3];  // [0]=EX, [1]=MEM, [2]=WB
  logic       ld_in_ex;
  logic       dep_rn;
  logic       dep_rm;
  logic       bubble;
  logic [1:0] a_sel_nxt;
  logic [1:0] b_sel_nxt;
  logic [1:0] fwd_a_sel_p0;
  logic [1:0] fwd_b_sel_p0;
  logic [CNT_W-1:0] stall_count_p0;

  // Load-use detection against the EX slot only; after one bubble the load
  // has moved to MEM and ordinary MEM/WB forwarding covers the dependency.
  always_comb begin
    ld_in_ex = slot_q[0].valid && slot_q[0].mem_read && slot_q[0].reg_write &&
               (REG_W'(slot_q[0].rd) != XZR);
    dep_rn   = id_uses_rn && (id_rn == REG_W'(slot_q[0].rd));
    dep_rm   = id_uses_rm && !id_use_imm && (id_rm == REG_W'(slot_q[0].rd));
    stall    = id_valid && !flush && ld_in_ex && (dep_rn || dep_rm);
  end

  always_comb begin
    bubble    = stall || flush || !id_valid;
    id_entry  = '0;
    a_sel_nxt = FWD_RF;
    b_sel_nxt = FWD_RF;
    if (!bubble) begin
      id_entry.valid     = 1'b1;
      id_entry.rd        = SLOT_RD_W'(id_rd);
      id_entry.reg_write = id_reg_write;
      id_entry.mem_read  = id_mem_read;
      if (id_uses_rn) begin
        a_sel_nxt = pick_src(slot_q[0], slot_q[1], id_rn);
      end
      if (id_use_imm) begin
        b_sel_nxt = FWD_IMM;
      end else if (id_uses_rm) begin
        b_sel_nxt = pick_src(slot_q[0], slot_q[1], id_rm);
      end
    end
  end

  // ID -> EX -> MEM -> WB tracking chain
  for (genvar i = 0; i < 3; i++) begin : g_slot
    if (i == 0) begin : g_head
      hazard_slot u_slot (.clk(clk), .reset(reset), .d(id_entry),    .q(slot_q[i]));
    end else begin : g_tail
      hazard_slot u_slot (.clk(clk), .reset(reset), .d(slot_q[i-1]), .q(slot_q[i]));
    end
  end

  // ID/EX boundary: selects for the instruction now entering EX
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_sel_p0   <= FWD_RF;
      fwd_b_sel_p0   <= FWD_RF;
      stall_count_p0 <= '0;
    end else begin
      fwd_a_sel_p0 <= a_sel_nxt;
      fwd_b_sel_p0 <= b_sel_nxt;
      if (stall) begin
        stall_count_p0 <= sat_inc(stall_count_p0);
      end
    end
  end

  assign fwd_a_sel   = fwd_a_sel_p0;
  assign fwd_b_sel   = fwd_b_sel_p0;
  assign stall_count = stall_count_p0;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
module tb_operand_forward_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rn, id_rm, id_rd;
  logic             id_uses_rn, id_uses_rm, id_use_imm;
  logic             id_reg_write, id_mem_read, flush;
  logic             stall;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  operand_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock; leave time 1 unit past the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rn, input int rm, input int rd,
                        input logic urn, input logic urm, input logic imm,
                        input logic rw, input logic mr, input logic fl);
    id_valid     = v;
    id_rn        = REG_W'(rn);
    id_rm        = REG_W'(rm);
    id_rd        = REG_W'(rd);
    id_uses_rn   = urn;
    id_uses_rm   = urm;
    id_use_imm   = imm;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  // ALU op rd <- rn op rm
  task automatic alu(input int rd, input int rn, input int rm);
    set_id(1, rn, rm, rd, 1, 1, 0, 1, 0, 0);
  endtask

  // LDUR rd, [rn]
  task automatic ldur(input int rd, input int rn);
    set_id(1, rn, 0, rd, 1, 0, 0, 1, 1, 0);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_cnt;

    // reset state
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    check("rst_a_sel", fwd_a_sel, 0);
    check("rst_b_sel", fwd_b_sel, 0);
    check("rst_stall", stall, 0);
    check("rst_count", stall_count, 0);
    reset = 1'b0;

    // back-to-back ALU: ADD X1,X2,X3 ; ADD X2,X1,X1
    alu(1, 2, 3);
    #1 check("alu1_stall", stall, 0);
    cyc();
    check("alu1_a", fwd_a_sel, 0);
    check("alu1_b", fwd_b_sel, 0);
    alu(2, 1, 1);
    #1 check("alu2_stall", stall, 0);
    cyc();
    check("b2b_a", fwd_a_sel, 1);
    check("b2b_b", fwd_b_sel, 1);

    // producer X3, unrelated, consumer rn=3 -> MEM/WB
    alu(3, 7, 8);
    cyc();
    alu(9, 10, 11);
    cyc();
    alu(12, 3, 10);
    cyc();
    check("gap_a", fwd_a_sel, 2);
    check("gap_b", fwd_b_sel, 0);

    // producers to X3 in both EX and MEM -> youngest (EX/MEM) wins
    alu(3, 0, 0);
    cyc();
    alu(3, 0, 0);
    cyc();
    alu(13, 3, 3);
    cyc();
    check("young_a", fwd_a_sel, 1);
    check("young_b", fwd_b_sel, 1);

    // load-use: LDUR X4 ; ADD X5,X4,X6
    ldur(4, 20);
    #1 check("ld_stall", stall, 0);
    cyc();
    alu(5, 4, 6);
    #1 check("lu_stall", stall, 1);
    check("lu_cnt0", stall_count, 0);
    cyc();
    check("lu_bub_a", fwd_a_sel, 0);
    check("lu_bub_b", fwd_b_sel, 0);
    check("lu_cnt1", stall_count, 1);
    #1 check("lu_retry_stall", stall, 0);
    cyc();
    check("lu_retry_a", fwd_a_sel, 2);
    check("lu_retry_b", fwd_b_sel, 0);
    check("lu_cnt_hold", stall_count, 1);

    // load-use with flush: flush wins
    ldur(4, 20);
    cyc();
    alu(5, 4, 6);
    flush = 1'b1;
    #1 check("fl_stall", stall, 0);
    cyc();
    check("fl_a", fwd_a_sel, 0);
    check("fl_b", fwd_b_sel, 0);
    check("fl_cnt", stall_count, 1);

    // XZR producer is never forwarded; immediate forces 11 on B
    alu(31, 1, 2);
    cyc();
    set_id(1, 31, 31, 14, 1, 1, 1, 1, 0, 0);
    cyc();
    check("xzr_a", fwd_a_sel, 0);
    check("xzr_b", fwd_b_sel, 3);
    alu(7, 0, 0);
    cyc();
    set_id(1, 0, 7, 15, 1, 1, 1, 1, 0, 0);
    cyc();
    check("imm_a", fwd_a_sel, 0);
    check("imm_b", fwd_b_sel, 3);
    ldur(31, 20);
    cyc();
    alu(16, 31, 31);
    #1 check("ldxzr_stall", stall, 0);
    cyc();
    check("ldxzr_a", fwd_a_sel, 0);
    check("ldxzr_b", fwd_b_sel, 0);

    // reset while a load is in EX and a dependent is in ID
    ldur(4, 20);
    cyc();
    alu(5, 4, 6);
    #1 check("pre_rst_stall", stall, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_a", fwd_a_sel, 0);
    check("mid_rst_b", fwd_b_sel, 0);
    check("mid_rst_cnt", stall_count, 0);
    #1 check("mid_rst_stall", stall, 0);
    cyc();
    check("post_rst_a", fwd_a_sel, 0);
    check("post_rst_b", fwd_b_sel, 0);

    // repeated load-use pairs saturate the 3-bit counter at 7
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      ldur(4, 20);
      cyc();
      alu(5, 4, 6);
      #1 check("sat_stall", stall, 1);
      cyc();
      if (exp_cnt < 7) exp_cnt++;
      check("sat_cnt", stall_count, exp_cnt);
      cyc();
    end
    check("sat_final", stall_count, 7);

    idle();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
